// File: rtl/scarv_cop_rng_arbiter.sv
// scarv_cop_rng_arbiter: prefetches random words from the coprocessor RNG
// source into a small FIFO. It serves two consumers with round-robin
// arbitration and sequences reseed requests onto the source.
// Optional feature macro: SCARV_COP_RNG_ARB_HEALTH_EN enables the
// repetition-count health test, the FAULT state and the sticky rng_fault.
//
// Handshake semantics: a consumer raises reqN_valid. reqN_ready is asserted
// combinationally in the cycle its word is granted. A word is transferred on
// every rising edge where reqN_valid && reqN_ready, and reqN_data carries that
// word in the same cycle. seed_valid is held until the one-cycle seed_ready.
// src_req and src_seed_valid are held until src_ack.
module scarv_cop_rng_arbiter #(
  parameter int DEPTH     = 4,
  parameter int HT_CUTOFF = 3
) (
  input  logic                       g_clk,
  input  logic                       g_reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  output logic [31:0]                req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  output logic [31:0]                req1_data,
  input  logic                       seed_valid,
  input  logic [31:0]                seed_data,
  output logic                       seed_ready,
  output logic                       src_req,
  output logic                       src_seed_valid,
  output logic [31:0]                src_seed,
  input  logic                       src_ack,
  input  logic [31:0]                src_data,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       rng_fault,
  output logic [1:0]                 dbg_state
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      HT_CUTOFF < 2 || HT_CUTOFF > 15) begin : g_bad_param
    $error("scarv_cop_rng_arbiter: DEPTH or HT_CUTOFF out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEED  = 2'd2
`ifdef SCARV_COP_RNG_ARB_HEALTH_EN
    , ST_FAULT = 2'd3
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            rr_pref;     // 0: req0 wins a tie, 1: req1 wins a tie
  logic            serve, grant0, grant1, pop, push, flush;
  logic            fetch_done, seed_done, seed_take, ht_trip;

  // Arbitration, datapath strobes and transfer qualifiers
  always_comb begin
    serve      = (state == ST_IDLE || state == ST_FETCH) && (count != '0);
    grant0     = serve && req0_valid && (!req1_valid || !rr_pref);
    grant1     = serve && req1_valid && (!req0_valid ||  rr_pref);
    pop        = grant0 || grant1;
    fetch_done = (state == ST_FETCH) && src_ack;
    seed_done  = (state == ST_SEED)  && src_ack;
    push       = fetch_done && !ht_trip;
    flush      = seed_done || ht_trip;
    seed_take  = seed_valid && (state == ST_IDLE
`ifdef SCARV_COP_RNG_ARB_HEALTH_EN
                 || state == ST_FAULT
`endif
                 );
  end

  // Next-state logic; seed requests take priority over prefetching
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (seed_valid)            state_nxt = ST_SEED;
        else if (count < CNT_FULL) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (src_ack) begin
`ifdef SCARV_COP_RNG_ARB_HEALTH_EN
          state_nxt = ht_trip ? ST_FAULT : ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_SEED: begin
        if (src_ack) state_nxt = ST_IDLE;
      end
`ifdef SCARV_COP_RNG_ARB_HEALTH_EN
      ST_FAULT: begin
        if (seed_valid) state_nxt = ST_SEED;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Seed value register, loaded when a seed request is accepted
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)        src_seed <= '0;
    else if (seed_take) src_seed <= seed_data;
  end

  // FIFO storage, pointers and occupancy; a flush drops every buffered word
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= src_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

  // Round-robin pointer: after a grant, the other requester wins the next tie
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)     rr_pref <= 1'b0;
    else if (grant0) rr_pref <= 1'b1;
    else if (grant1) rr_pref <= 1'b0;
  end

`ifdef SCARV_COP_RNG_ARB_HEALTH_EN
  localparam logic [3:0] HT_LIM = 4'(HT_CUTOFF);
  logic [31:0] last_word;
  logic        have_last;
  logic [3:0]  rep_cnt, rep_nxt;
  logic        fault_q;

  assign rep_nxt   = (have_last && src_data == last_word) ? rep_cnt + 4'd1 : 4'd1;
  assign ht_trip   = fetch_done && (rep_nxt >= HT_LIM);
  assign rng_fault = fault_q;

  // Repetition history and sticky fault; a completed seed clears them all
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      last_word <= '0;
      have_last <= 1'b0;
      rep_cnt   <= '0;
      fault_q   <= 1'b0;
    end else if (seed_done) begin
      last_word <= '0;
      have_last <= 1'b0;
      rep_cnt   <= '0;
      fault_q   <= 1'b0;
    end else if (fetch_done) begin
      last_word <= src_data;
      have_last <= 1'b1;
      rep_cnt   <= rep_nxt;
      if (ht_trip) fault_q <= 1'b1;
    end
  end
`else
  assign ht_trip   = 1'b0;
  assign rng_fault = 1'b0;
`endif

  assign req0_ready     = grant0;
  assign req1_ready     = grant1;
  assign req0_data      = mem[rd_ptr];
  assign req1_data      = mem[rd_ptr];
  assign seed_ready     = seed_done;
  assign src_req        = (state == ST_FETCH);
  assign src_seed_valid = (state == ST_SEED);
  assign fill_level     = count;
  assign dbg_state      = state;

endmodule

// File: tb/tb_scarv_cop_rng_arbiter.sv
// Testbench for scarv_cop_rng_arbiter. A source driver answers fetch and
// seed requests and queues every fetched word as an expected response. The
// monitor checks each grant against a plain FIFO + round-robin reference.
`timescale 1ns/1ps
module tb_scarv_cop_rng_arbiter;
  localparam int DEPTH = 4;

  logic        g_clk = 1'b0, g_reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        seed_valid, seed_ready, src_req, src_seed_valid, src_ack;
  logic [31:0] seed_data, src_seed, src_data;
  logic [2:0]  fill_level;
  logic        rng_fault;
  logic [1:0]  dbg_state;

  scarv_cop_rng_arbiter #(.DEPTH(DEPTH), .HT_CUTOFF(3)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .src_req(src_req), .src_seed_valid(src_seed_valid), .src_seed(src_seed),
    .src_ack(src_ack), .src_data(src_data), .fill_level(fill_level),
    .rng_fault(rng_fault), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 g_clk = ~g_clk;

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];     // words the DUT should hold, oldest first
  logic [31:0] dir_q[$];     // directed source words, used before random ones
  logic [31:0] pop_data[$];
  int          pop_port[$];
  int          model_fill, last_served, seed_pulses;
  int          max_wait, seed_wait;
  bit          mon_en, src_stall, seed_seen;
  logic [31:0] cur_seed;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_fill  = 0;
    last_served = 1;
  endtask

  // source driver: acks requests after a chosen wait, queues fetched words
  initial begin : src_drv
    bit prev;
    int cnt;
    prev = 0; cnt = 0;
    src_ack = 1'b0; src_data = '0;
    forever begin
      tick();
      src_ack = 1'b0;
      if (g_reset) begin
        prev = 0;
      end else if (src_req || src_seed_valid) begin
        if (!prev) cnt = src_seed_valid ? seed_wait : $urandom_range(0, max_wait);
        if (cnt == 0 && !src_stall) begin
          src_ack = 1'b1;
          if (src_req) begin
            src_data = (dir_q.size() != 0) ? dir_q.pop_front() : $urandom;
            exp_q.push_back(src_data);
          end
        end else if (cnt > 0) begin
          cnt--;
        end
        prev = 1;
      end else begin
        prev = 0;
      end
    end
  end

  // monitor / scoreboard: reference FIFO, round-robin rule and seed flush
  initial begin : monitor
    logic        want0, want1;
    logic [1:0]  exp_g;
    logic [31:0] w;
    forever begin
      @(negedge g_clk);
      if (!g_reset && mon_en) begin
        check("fill_level", 64'(fill_level), 64'(model_fill));
        want0 = req0_valid && model_fill > 0 && !src_seed_valid;
        want1 = req1_valid && model_fill > 0 && !src_seed_valid;
        exp_g = 2'b00;
        if (want0 && want1) exp_g = (last_served == 0) ? 2'b10 : 2'b01;
        else if (want0)     exp_g = 2'b01;
        else if (want1)     exp_g = 2'b10;
        check("grant", 64'({req1_ready, req0_ready}), 64'(exp_g));
        if (req0_ready || req1_ready) begin
          if (exp_q.size() == 0) begin
            check("pop_nonempty", 64'(exp_q.size()), 64'd1);
          end else begin
            w = exp_q.pop_front();
            check("req0_data", 64'(req0_data), 64'(w));
            check("req1_data", 64'(req1_data), 64'(w));
          end
          pop_data.push_back(req0_data);
          pop_port.push_back(req1_ready ? 1 : 0);
          last_served = req1_ready ? 1 : 0;
          model_fill--;
        end
        if (src_req && src_ack) model_fill++;
        if (src_seed_valid) check("src_seed", 64'(src_seed), 64'(cur_seed));
        if (seed_ready) begin
          seed_pulses++;
          exp_q.delete();
          model_fill = 0;
          seed_seen  = 1;
        end
      end
    end
  end

  initial begin : stim
    int n;
    g_reset = 1'b1; req0_valid = 0; req1_valid = 0;
    seed_valid = 0; seed_data = '0; cur_seed = '0;
    src_stall = 0; max_wait = 0; seed_wait = 0; mon_en = 0;
    seed_pulses = 0; seed_seen = 0;
    reset_model();
    dir_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    repeat (3) tick();
    check("rst_ctrl", 64'({src_req, src_seed_valid, seed_ready, req0_ready,
                          req1_ready, rng_fault, fill_level}), 64'd0);
    check("rst_data", {req0_data, req1_data}, 64'd0);
    check("rst_src_seed", 64'(src_seed), 64'd0);
    g_reset = 1'b0;
    mon_en  = 1;

    // fill to DEPTH from a zero-wait source, then prefetch must stop
    n = 0;
    while (fill_level != 3'(DEPTH) && n < 30) begin tick(); n++; end
    check("fill_reaches_depth", 64'(fill_level), 64'(DEPTH));
    repeat (4) begin tick(); check("src_req_idle_when_full", 64'(src_req), 64'd0); end

    // both requesters held: grants alternate and drain in order
    pop_data.delete(); pop_port.delete();
    req0_valid = 1; req1_valid = 1;
    repeat (4) tick();
    req0_valid = 0; req1_valid = 0;
    check("pop_count", 64'(pop_data.size()), 64'd4);
    for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
      check("alt_data", 64'(pop_data[i]), 64'(32'h11 * (i + 1)));
      check("alt_port", 64'(pop_port[i]), 64'(i % 2));
    end

    // seed with 3 buffered words (pop and seed accepted in the same cycle)
    n = 0;
    while (fill_level != 3'(DEPTH) && n < 30) begin tick(); n++; end
    seed_pulses = 0; seed_seen = 0; seed_wait = 2;
    cur_seed = 32'hDEADBEEF; seed_data = 32'hDEADBEEF; seed_valid = 1;
    req0_valid = 1;
    tick();
    req1_valid = 1;
    check("fill_at_seed", 64'(fill_level), 64'(DEPTH - 1));
    n = 0;
    while (!seed_seen && n < 20) begin tick(); n++; end
    seed_valid = 0; seed_seen = 0;
    check("fill_after_seed", 64'(fill_level), 64'd0);
    repeat (8) tick();
    req0_valid = 0; req1_valid = 0;
    check("seed_pulses", 64'(seed_pulses), 64'd1);

    // push and pop in the same cycle at DEPTH-1
    n = 0;
    while (!(fill_level == 3'(DEPTH - 1) && src_req) && n < 30) begin tick(); n++; end
    check("found_full_minus_1", 64'(n < 30), 64'd1);
    req0_valid = 1;
    tick();
    req0_valid = 0;
    check("push_pop_level", 64'(fill_level), 64'(DEPTH - 1));

    // randomized traffic with occasional reseeds and a slow source
    max_wait = 3;
    for (int c = 0; c < 3000; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      if (seed_valid && seed_seen) begin
        seed_valid = 0; seed_seen = 0;
      end else if (!seed_valid && $urandom_range(0, 63) == 0) begin
        seed_data = $urandom; cur_seed = seed_data;
        seed_wait = $urandom_range(0, 3); seed_seen = 0; seed_valid = 1;
      end
      tick();
    end
    n = 0;
    while (seed_valid && !seed_seen && n < 40) begin tick(); n++; end
    seed_valid = 0; seed_seen = 0; req0_valid = 0; req1_valid = 0;

    // asynchronous reset while a fetch is outstanding
    max_wait = 0;
    repeat (6) tick();
    src_stall = 1;
    n = 0;
    while (!src_req && n < 20) begin tick(); n++; end
    check("stalled_src_req", 64'(src_req), 64'd1);
    @(negedge g_clk); #2;
    g_reset = 1'b1; mon_en = 0;
    #1;
    check("async_rst_ctrl", 64'({src_req, src_seed_valid, seed_ready, req0_ready,
                                req1_ready, rng_fault, fill_level}), 64'd0);
    check("async_rst_data", {req0_data, req1_data}, 64'd0);
    check("async_rst_src_seed", 64'(src_seed), 64'd0);
    tick();
    reset_model();
    src_stall = 0; g_reset = 1'b0; mon_en = 1;
    n = 0;
    while (!src_req && n < 10) begin tick(); n++; end
    check("fetch_restart", 64'(src_req), 64'd1);
    for (int c = 0; c < 200; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      tick();
    end
    req0_valid = 0; req1_valid = 0;

`ifdef SCARV_COP_RNG_ARB_HEALTH_EN
    // repetition-count health test: three identical words trip the fault
    mon_en = 0; g_reset = 1'b1;
    tick();
    dir_q = '{32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A};
    g_reset = 1'b0;
    n = 0;
    while (!rng_fault && n < 30) begin tick(); n++; end
    check("ht_fault", 64'(rng_fault), 64'd1);
    check("ht_flushed", 64'(fill_level), 64'd0);
    req0_valid = 1;
    repeat (5) begin
      tick();
      check("ht_no_fetch_no_grant", 64'({src_req, req0_ready}), 64'd0);
    end
    req0_valid = 0;
    dir_q.delete();
    seed_data = 32'h0BADF00D; seed_wait = 1; seed_valid = 1;
    n = 0;
    do begin @(negedge g_clk); n++; end while (!seed_ready && n < 20);
    check("ht_seed_done", 64'(seed_ready), 64'd1);
    tick();
    seed_valid = 0;
    check("ht_fault_cleared", 64'(rng_fault), 64'd0);
    n = 0;
    while (!src_req && n < 10) begin tick(); n++; end
    check("ht_fetch_resumes", 64'(src_req), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
